// File: rtl/game_pkg.sv
// Shared game constants and types for the obstacle / scoring datapath.
package game_pkg;
  localparam int         NUM_OBS     = 10;
  localparam int         SCREEN_W    = 640;
  localparam logic [9:0] OFFSCREEN_X = 10'd640;
  localparam logic [9:0] PLAYER_X    = 10'd100;
  // Parked position of a despawned obstacle; also the reset value of prev_x.
  localparam logic [9:0] RESPAWN_X   = 10'd700;

  typedef logic [9:0] obs_x_t;

  typedef enum logic [1:0] {
    GM_IDLE  = 2'b00,
    GM_RUN   = 2'b01,
    GM_OVER  = 2'b10,
    GM_PAUSE = 2'b11
  } gamemode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_COMMIT
  } sk_state_t;
endpackage

// File: rtl/score_keeper_if.sv
// Bus between the game logic / display path and score_keeper.
// master drives the game state, slave (score_keeper) returns the score.
interface score_keeper_if import game_pkg::*; #(
  parameter int SCORE_W = 14
) ();
  logic                        frame_tick;
  gamemode_t                   gamemode;
  obs_x_t [NUM_OBS-1:0]        obstacle_x_right;
  logic [SCORE_W-1:0]          score;
  logic [SCORE_W-1:0]          best_score;
  logic                        new_record;
  logic                        score_upd;
  logic                        busy;
  logic                        overrun;

  modport master (
    output frame_tick, gamemode, obstacle_x_right,
    input  score, best_score, new_record, score_upd, busy, overrun
  );

  modport slave (
    input  frame_tick, gamemode, obstacle_x_right,
    output score, best_score, new_record, score_upd, busy, overrun
  );
endinterface

// File: rtl/score_keeper_pass_detect.sv
// Edge rule for one obstacle slot: it scores only when it was on screen at or
// right of the player column last frame and is now left of the player.
// Respawns (small x jumping large) and parked slots can never satisfy this.
module pass_detect import game_pkg::*; (
  input  obs_x_t i_prev_x,
  input  obs_x_t i_cur_x,
  output logic   o_passed
);
  assign o_passed = (i_prev_x >= PLAYER_X) && (i_prev_x < OFFSCREEN_X) &&
                    (i_cur_x < PLAYER_X);
endmodule

// File: rtl/score_keeper.sv
// score_keeper: serial per-frame obstacle scan, saturating score, session best.
// Optional feature macro: SCORE_HIGH_SCORE_EN (builds best_score/new_record;
// when undefined both outputs are tied to 0).
module score_keeper import game_pkg::*; #(
  parameter int SCORE_W   = 14,
  parameter int SCORE_MAX = 9999
) (
  input  logic           clk,
  input  logic           rst,
  score_keeper_if.slave  io_bus
);
  localparam int IDX_W = $clog2(NUM_OBS);
  localparam int ACC_W = $clog2(NUM_OBS + 1);
  localparam int SUM_W = SCORE_W + 4;
  localparam logic [SUM_W-1:0] SAT_SUM  = SUM_W'(SCORE_MAX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBS - 1);

  sk_state_t            r_state, w_state_nxt;
  obs_x_t [NUM_OBS-1:0] r_snap, r_prev_x;
  logic [IDX_W-1:0]     r_idx;
  logic [ACC_W-1:0]     r_acc;
  logic [SCORE_W-1:0]   r_score, w_score_nxt;
  logic [SUM_W-1:0]     w_sum;
  logic                 r_score_upd, r_overrun;
  logic                 w_passed, w_busy, w_start, w_copy, w_scan, w_commit;
  gamemode_t            w_gm;

  assign w_gm = io_bus.gamemode;

  pass_detect u_pass (
    .i_prev_x (r_prev_x[r_idx]),
    .i_cur_x  (r_snap[r_idx]),
    .o_passed (w_passed)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state; leaving run mode aborts a scan without committing
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (io_bus.frame_tick && w_gm == GM_RUN) w_state_nxt = ST_SCAN;
      ST_SCAN:   if (w_gm != GM_RUN)          w_state_nxt = ST_IDLE;
                 else if (r_idx == LAST_IDX)  w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM decoded controls
  always_comb begin
    w_busy   = (r_state != ST_IDLE);
    w_start  = (r_state == ST_IDLE) && io_bus.frame_tick && (w_gm == GM_RUN);
    w_copy   = (r_state == ST_IDLE) && io_bus.frame_tick && (w_gm != GM_RUN);
    w_scan   = (r_state == ST_SCAN) && (w_gm == GM_RUN);
    w_commit = (r_state == ST_COMMIT) && (w_gm == GM_RUN);
  end

  // Next score: idle clears (wins over commit), commit adds with saturation
  always_comb begin
    w_sum       = SUM_W'(r_score) + SUM_W'(r_acc);
    w_score_nxt = r_score;
    if (w_gm == GM_IDLE)
      w_score_nxt = '0;
    else if (w_commit)
      w_score_nxt = (w_sum > SAT_SUM) ? SCORE_W'(SCORE_MAX) : w_sum[SCORE_W-1:0];
  end

  // Snapshot, per-slot scan, accumulator, score and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap      <= '0;
      r_prev_x    <= {NUM_OBS{RESPAWN_X}};
      r_idx       <= '0;
      r_acc       <= '0;
      r_score     <= '0;
      r_score_upd <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_score     <= w_score_nxt;
      // saturated commits leave score unchanged and do not pulse
      r_score_upd <= w_commit && (w_score_nxt != r_score);
      if (io_bus.frame_tick && w_busy) r_overrun <= 1'b1;
      if (w_start) begin
        r_snap <= io_bus.obstacle_x_right;
        r_acc  <= '0;
        r_idx  <= '0;
      end
      if (w_copy) r_prev_x <= io_bus.obstacle_x_right;
      if (w_scan) begin
        r_acc           <= r_acc + ACC_W'(w_passed);
        r_prev_x[r_idx] <= r_snap[r_idx];
        r_idx           <= r_idx + 1'b1;
      end
    end
  end

  assign io_bus.score     = r_score;
  assign io_bus.score_upd = r_score_upd;
  assign io_bus.busy      = w_busy;
  assign io_bus.overrun   = r_overrun;

`ifdef SCORE_HIGH_SCORE_EN
  logic [SCORE_W-1:0] r_best;
  logic               r_new_record;
  gamemode_t          r_gm_prev;

  // Best latched on run->over; record flag tracks in run, holds until idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_best       <= '0;
      r_new_record <= 1'b0;
      r_gm_prev    <= GM_IDLE;
    end else begin
      r_gm_prev <= w_gm;
      if (r_gm_prev == GM_RUN && w_gm == GM_OVER && r_score > r_best)
        r_best <= r_score;
      if (w_gm == GM_IDLE)     r_new_record <= 1'b0;
      else if (w_gm == GM_RUN) r_new_record <= (w_score_nxt > r_best);
    end
  end

  assign io_bus.best_score = r_best;
  assign io_bus.new_record = r_new_record;
`else
  assign io_bus.best_score = '0;
  assign io_bus.new_record = 1'b0;
`endif
endmodule
